y_alu_mc: RTL and testbench

Multi-cycle, parametrised successor to the single-cycle 32-bit ALU. It keeps the combinational operations (and, or, add, sub, slt) and adds unsigned shift-add multiply, restoring divide and remainder, signed overflow reporting and a valid/ready handshake on both sides. It sits between the register-file read stage and write-back, and stalls the pipeline while an iterative operation runs.

---
 rtl/y_alu_mc.sv | 145 ++++++++++++++
 tb/tb_y_alu_mc.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/y_alu_mc.sv
// Multi-cycle ALU: single-cycle logic/arithmetic ops plus iterative shift-add multiply
// and restoring divide/remainder, with valid/ready handshakes on both sides.
module y_alu_mc #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic [3:0]   op,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] z,
   output logic         zero,
   output logic         ovf
);

   localparam int CW = $clog2(W) + 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);

   localparam logic [3:0] OP_AND = 4'b0000;
   localparam logic [3:0] OP_OR  = 4'b0001;
   localparam logic [3:0] OP_ADD = 4'b0010;
   localparam logic [3:0] OP_SUB = 4'b0110;
   localparam logic [3:0] OP_SLT = 4'b0111;
   localparam logic [3:0] OP_MUL = 4'b1000;
   localparam logic [3:0] OP_DIV = 4'b1010;
   localparam logic [3:0] OP_REM = 4'b1011;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t         state, state_nxt;
   logic [CW-1:0]  cnt;
   logic [3:0]     op_r;
   logic [2*W-1:0] prod, prod_nxt;
   logic [W:0]     sum_hi;
   logic [W-1:0]   mcand;
   logic [W-1:0]   quo, quo_nxt;
   logic [W-1:0]   rem, rem_nxt;
   logic [W:0]     rem_sh;
   logic [W-1:0]   dvsr;
   logic           ge;
   logic [W-1:0]   run_z;
   logic [W:0]     sc_res;
   logic           is_iter;

   // Returns {ovf, z} for the single-cycle ops; undefined codes give zero.
   function automatic logic [W:0] alu_single(input logic [3:0] f,
                                              input logic [W-1:0] x,
                                              input logic [W-1:0] y);
      logic signed [W-1:0] sum, dif;
      logic                ovf_add, ovf_sub;
      sum     = x + y;
      dif     = x + ~y + W'(1);
      ovf_add = (x[W-1] == y[W-1]) && (sum[W-1] != x[W-1]);
      ovf_sub = (x[W-1] != y[W-1]) && (dif[W-1] != x[W-1]);
      case (f)
         OP_AND:  alu_single = {1'b0, x & y};
         OP_OR:   alu_single = {1'b0, x | y};
         OP_ADD:  alu_single = {ovf_add, sum};
         OP_SUB:  alu_single = {ovf_sub, dif};
         OP_SLT:  alu_single = {1'b0, {(W-1){1'b0}}, dif[W-1] ^ ovf_sub};
         default: alu_single = '0;
      endcase
   endfunction

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);
   assign is_iter   = (op == OP_MUL) || (op == OP_DIV) || (op == OP_REM);
   assign sc_res    = alu_single(op, a, b);

   // One multiply step and one restoring-divide step per RUN cycle.
   always_comb begin
      sum_hi   = {1'b0, prod[2*W-1:W]} + (prod[0] ? {1'b0, mcand} : {(W+1){1'b0}});
      prod_nxt = {sum_hi, prod[W-1:1]};
      rem_sh   = {rem, quo[W-1]};
      ge       = (rem_sh >= {1'b0, dvsr});
      rem_nxt  = ge ? (rem_sh[W-1:0] - dvsr) : rem_sh[W-1:0];
      quo_nxt  = {quo[W-2:0], ge};
      case (op_r)
         OP_MUL:  run_z = prod_nxt[W-1:0];
         OP_DIV:  run_z = quo_nxt;
         default: run_z = rem_nxt;
      endcase
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (in_valid) state_nxt = is_iter ? RUN : DONE;
         RUN:  if (cnt == CNT_LAST) state_nxt = DONE;
         DONE: if (out_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         cnt   <= '0;
         z     <= '0;
         zero  <= 1'b0;
         ovf   <= 1'b0;
      end else begin
         state <= state_nxt;
         case (state)
            IDLE: if (in_valid) begin
               cnt <= '0;
               if (!is_iter) begin
                  z    <= sc_res[W-1:0];
                  zero <= (sc_res[W-1:0] == '0);
                  ovf  <= sc_res[W];
               end
            end
            RUN: if (cnt == CNT_LAST) begin
               z    <= run_z;
               zero <= (run_z == '0);
               ovf  <= 1'b0;
            end else begin
               cnt <= cnt + CW'(1);
            end
            default: ;
         endcase
      end
   end

   // Working registers carry no reset; they are always loaded at acceptance.
   always_ff @(posedge clk) begin
      if (state == IDLE && in_valid) begin
         op_r  <= op;
         mcand <= a;
         prod  <= {{W{1'b0}}, b};
         dvsr  <= b;
         quo   <= a;
         rem   <= '0;
      end else if (state == RUN) begin
         prod <= prod_nxt;
         quo  <= quo_nxt;
         rem  <= rem_nxt;
      end
   end

endmodule

// File: tb/tb_y_alu_mc.sv
// Directed bench for y_alu_mc: vector table at W=32, handshake corner sequences,
// and a W=8 instance for the parametric multiply/divide cases.
module tb_y_alu_mc;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid, in_ready, out_valid, out_ready;
   logic [31:0] a, b, z;
   logic [3:0]  op;
   logic        zero, ovf;

   logic        in_valid8, in_ready8, out_valid8, out_ready8;
   logic [7:0]  a8, b8, z8;
   logic [3:0]  op8;
   logic        zero8, ovf8;

   int nvec = 0;
   int nerr = 0;

   always #5 clk = ~clk;

   y_alu_mc #(.W(32)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
      .z(z), .zero(zero), .ovf(ovf)
   );

   y_alu_mc #(.W(8)) dut8 (
      .clk(clk), .reset(reset), .in_valid(in_valid8), .in_ready(in_ready8),
      .a(a8), .b(b8), .op(op8), .out_valid(out_valid8), .out_ready(out_ready8),
      .z(z8), .zero(zero8), .ovf(ovf8)
   );

   typedef struct {
      logic [3:0]  op;
      logic [31:0] a, b, z;
      logic        zero, ovf;
      int          lat;
   } vec_t;

   localparam int NV = 19;
   vec_t tbl [NV];

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic run32(input logic [3:0] f, input logic [31:0] x, input logic [31:0] y,
                        output logic [31:0] rz, output logic rzero, output logic rovf,
                        output int lat);
      int guard = 0;
      while (!in_ready && guard < 100) begin
         tick;
         guard++;
      end
      op = f; a = x; b = y; in_valid = 1'b1;
      tick;
      in_valid = 1'b0;
      a = 32'hDEADBEEF; b = 32'h12345678; op = 4'b0000;
      lat = 1;
      while (!out_valid && lat < 100) begin
         tick;
         lat++;
      end
      rz = z; rzero = zero; rovf = ovf;
      tick;
   endtask

   task automatic run8(input logic [3:0] f, input logic [7:0] x, input logic [7:0] y,
                       output logic [7:0] rz, output int lat);
      int guard = 0;
      while (!in_ready8 && guard < 100) begin
         tick;
         guard++;
      end
      op8 = f; a8 = x; b8 = y; in_valid8 = 1'b1;
      tick;
      in_valid8 = 1'b0;
      a8 = 8'hFF; b8 = 8'hFF;
      lat = 1;
      while (!out_valid8 && lat < 100) begin
         tick;
         lat++;
      end
      rz = z8;
      tick;
   endtask

   initial begin
      logic [31:0] rz;
      logic [7:0]  rz8;
      logic        rzero, rovf, seen;
      int          lat;

      //            op       a             b             z             zero  ovf   lat
      tbl[0]  = '{4'b0010, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b1, 1};
      tbl[1]  = '{4'b0110, 32'h00000005, 32'h00000005, 32'h00000000, 1'b1, 1'b0, 1};
      tbl[2]  = '{4'b0111, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b0, 1'b0, 1};
      tbl[3]  = '{4'b0111, 32'h80000000, 32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 1};
      tbl[4]  = '{4'b0111, 32'h00000001, 32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0, 1};
      tbl[5]  = '{4'b0000, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0, 1'b0, 1};
      tbl[6]  = '{4'b0001, 32'h0F0F0000, 32'h000000FF, 32'h0F0F00FF, 1'b0, 1'b0, 1};
      tbl[7]  = '{4'b0010, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b0, 1};
      tbl[8]  = '{4'b0110, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b0, 1'b1, 1};
      tbl[9]  = '{4'b0011, 32'h00000005, 32'h00000005, 32'h00000000, 1'b1, 1'b0, 1};
      tbl[10] = '{4'b1000, 32'h00010000, 32'h00010000, 32'h00000000, 1'b1, 1'b0, 33};
      tbl[11] = '{4'b1000, 32'd123,      32'd456,      32'd56088,    1'b0, 1'b0, 33};
      tbl[12] = '{4'b1000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 33};
      tbl[13] = '{4'b1010, 32'd100,      32'd7,        32'd14,       1'b0, 1'b0, 33};
      tbl[14] = '{4'b1011, 32'd100,      32'd7,        32'd2,        1'b0, 1'b0, 33};
      tbl[15] = '{4'b1010, 32'd5,        32'd0,        32'hFFFFFFFF, 1'b0, 1'b0, 33};
      tbl[16] = '{4'b1011, 32'd5,        32'd0,        32'd5,        1'b0, 1'b0, 33};
      tbl[17] = '{4'b1010, 32'hFFFFFFFF, 32'd10,       32'h19999999, 1'b0, 1'b0, 33};
      tbl[18] = '{4'b1011, 32'hFFFFFFFF, 32'd10,       32'd5,        1'b0, 1'b0, 33};

      reset = 1'b1;
      in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; op = '0;
      in_valid8 = 1'b0; out_ready8 = 1'b1; a8 = '0; b8 = '0; op8 = '0;
      repeat (3) tick;
      chk("reset in_ready", {31'd0, in_ready}, 32'd1);
      chk("reset out_valid", {31'd0, out_valid}, 32'd0);
      chk("reset z", z, 32'd0);
      chk("reset zero", {31'd0, zero}, 32'd0);
      chk("reset ovf", {31'd0, ovf}, 32'd0);
      reset = 1'b0;
      tick;
      chk("idle out_ready no effect", {31'd0, out_valid}, 32'd0);

      for (int i = 0; i < NV; i++) begin
         run32(tbl[i].op, tbl[i].a, tbl[i].b, rz, rzero, rovf, lat);
         chk($sformatf("v%0d z", i), rz, tbl[i].z);
         chk($sformatf("v%0d zero", i), {31'd0, rzero}, {31'd0, tbl[i].zero});
         chk($sformatf("v%0d ovf", i), {31'd0, rovf}, {31'd0, tbl[i].ovf});
         chk($sformatf("v%0d latency", i), lat, tbl[i].lat);
      end

      // Backpressure: result held while out_ready is low, new requests ignored.
      out_ready = 1'b0;
      op = 4'b0000; a = 32'hF0F0F0F0; b = 32'hFF00FF00; in_valid = 1'b1;
      tick;
      chk("bp out_valid", {31'd0, out_valid}, 32'd1);
      chk("bp z", z, 32'hF000F000);
      for (int i = 0; i < 5; i++) begin
         op = 4'b0010; a = 32'd1; b = 32'd1; in_valid = 1'b1;
         tick;
         chk($sformatf("bp hold z %0d", i), z, 32'hF000F000);
         chk($sformatf("bp in_ready %0d", i), {31'd0, in_ready}, 32'd0);
         chk($sformatf("bp out_valid %0d", i), {31'd0, out_valid}, 32'd1);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      tick;
      chk("bp release in_ready", {31'd0, in_ready}, 32'd1);
      chk("bp release out_valid", {31'd0, out_valid}, 32'd0);

      // Reset in the tenth cycle of a divide.
      op = 4'b1010; a = 32'd100; b = 32'd7; in_valid = 1'b1;
      tick;
      in_valid = 1'b0;
      repeat (9) tick;
      chk("mid div in_ready", {31'd0, in_ready}, 32'd0);
      reset = 1'b1;
      tick;
      reset = 1'b0;
      chk("abort in_ready", {31'd0, in_ready}, 32'd1);
      chk("abort out_valid", {31'd0, out_valid}, 32'd0);
      chk("abort z", z, 32'd0);
      seen = 1'b0;
      repeat (40) begin
         tick;
         if (out_valid) seen = 1'b1;
      end
      chk("abort no stale result", {31'd0, seen}, 32'd0);
      run32(4'b0010, 32'd2, 32'd3, rz, rzero, rovf, lat);
      chk("after abort add z", rz, 32'd5);
      chk("after abort add latency", lat, 1);

      // Parametric W=8 cases.
      run8(4'b1000, 8'd200, 8'd3, rz8, lat);
      chk("w8 mul z", {24'd0, rz8}, 32'h58);
      chk("w8 mul latency", lat, 9);
      run8(4'b1010, 8'd200, 8'd3, rz8, lat);
      chk("w8 divu z", {24'd0, rz8}, 32'd66);
      chk("w8 divu latency", lat, 9);
      run8(4'b1011, 8'd200, 8'd3, rz8, lat);
      chk("w8 remu z", {24'd0, rz8}, 32'd2);
      chk("w8 remu latency", lat, 9);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
